// File: rtl/change_dispenser.sv
`default_nettype none
// ============================================================================
// Module      : change_dispenser
// Description : Pays out change in 10-unit steps, one hopper coin at a time,
//               preferring 20-coins; tracks coin stock, shortfall and jams.
// Revision    : 1.0
// ============================================================================
module change_dispenser #(
   parameter int AMT_W       = 3,
   parameter int CNT_W       = 6,
   parameter int INIT_10     = 8,
   parameter int INIT_20     = 8,
   parameter int ACK_TIMEOUT = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             req,
   input  logic [AMT_W-1:0] amount,
   input  logic             hopper_ack,
   input  logic             refill,
   input  logic [CNT_W-1:0] refill_10,
   input  logic [CNT_W-1:0] refill_20,
   output logic             busy,
   output logic             pay_10,
   output logic             pay_20,
   output logic             done,
   output logic             short,
   output logic [AMT_W-1:0] unpaid,
   output logic             jam,
   output logic [CNT_W-1:0] stock_10,
   output logic [CNT_W-1:0] stock_20
);

   localparam int              TMO_W     = $clog2(ACK_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SELECT = 2'd1,
      S_EJECT  = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [AMT_W-1:0]   rem_q, rem_d;
   logic [TMO_W-1:0]   tmo_q, tmo_d;
   logic [CNT_W-1:0]   stock_10_q, stock_10_d;
   logic [CNT_W-1:0]   stock_20_q, stock_20_d;
   logic               busy_q, busy_d;
   logic               pay_10_q, pay_10_d;
   logic               pay_20_q, pay_20_d;
   logic               done_q, done_d;
   logic               short_q, short_d;
   logic [AMT_W-1:0]   unpaid_q, unpaid_d;
   logic               jam_q, jam_d;

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
      logic [CNT_W:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[CNT_W] ? C_CNT_MAX : sum[CNT_W-1:0];
   endfunction

   always_comb begin
      state_d    = state_q;
      rem_d      = rem_q;
      tmo_d      = tmo_q;
      stock_10_d = stock_10_q;
      stock_20_d = stock_20_q;
      pay_10_d   = pay_10_q;
      pay_20_d   = pay_20_q;
      done_d     = 1'b0;
      short_d    = short_q;
      unpaid_d   = unpaid_q;
      jam_d      = jam_q;

      case (state_q)
         S_IDLE: begin
            if (refill) begin
               stock_10_d = sat_add(stock_10_q, refill_10);
               stock_20_d = sat_add(stock_20_q, refill_20);
            end
            if (req) begin
               if (jam_q) begin
                  state_d  = S_DONE;
                  done_d   = 1'b1;
                  short_d  = 1'b1;
                  unpaid_d = amount;
               end else begin
                  rem_d   = amount;
                  state_d = S_SELECT;
               end
            end
         end
         S_SELECT: begin
            tmo_d = '0;
            if (rem_q == '0) begin
               state_d  = S_DONE;
               done_d   = 1'b1;
               short_d  = 1'b0;
               unpaid_d = '0;
            end else if (rem_q >= AMT_W'(2) && stock_20_q != '0) begin
               state_d  = S_EJECT;
               pay_20_d = 1'b1;
            end else if (stock_10_q != '0) begin
               state_d  = S_EJECT;
               pay_10_d = 1'b1;
            end else begin
               state_d  = S_DONE;
               done_d   = 1'b1;
               short_d  = 1'b1;
               unpaid_d = rem_q;
            end
         end
         S_EJECT: begin
            if (hopper_ack) begin
               pay_10_d = 1'b0;
               pay_20_d = 1'b0;
               tmo_d    = '0;
               state_d  = S_SELECT;
               if (pay_20_q) begin
                  stock_20_d = stock_20_q - CNT_W'(1);
                  rem_d      = rem_q - AMT_W'(2);
               end else begin
                  stock_10_d = stock_10_q - CNT_W'(1);
                  rem_d      = rem_q - AMT_W'(1);
               end
            end else if (tmo_q == TMO_W'(ACK_TIMEOUT - 1)) begin
               // The coin may or may not have left; stock is left untouched.
               pay_10_d = 1'b0;
               pay_20_d = 1'b0;
               tmo_d    = '0;
               jam_d    = 1'b1;
               state_d  = S_DONE;
               done_d   = 1'b1;
               short_d  = 1'b1;
               unpaid_d = rem_q;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         rem_q      <= '0;
         tmo_q      <= '0;
         stock_10_q <= CNT_W'(INIT_10);
         stock_20_q <= CNT_W'(INIT_20);
         busy_q     <= 1'b0;
         pay_10_q   <= 1'b0;
         pay_20_q   <= 1'b0;
         done_q     <= 1'b0;
         short_q    <= 1'b0;
         unpaid_q   <= '0;
         jam_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         rem_q      <= rem_d;
         tmo_q      <= tmo_d;
         stock_10_q <= stock_10_d;
         stock_20_q <= stock_20_d;
         busy_q     <= busy_d;
         pay_10_q   <= pay_10_d;
         pay_20_q   <= pay_20_d;
         done_q     <= done_d;
         short_q    <= short_d;
         unpaid_q   <= unpaid_d;
         jam_q      <= jam_d;
      end
   end

   assign busy     = busy_q;
   assign pay_10   = pay_10_q;
   assign pay_20   = pay_20_q;
   assign done     = done_q;
   assign short    = short_q;
   assign unpaid   = unpaid_q;
   assign jam      = jam_q;
   assign stock_10 = stock_10_q;
   assign stock_20 = stock_20_q;

endmodule
`default_nettype wire

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Pays out change owed by the vending FSM: accepts a change amount in 10-unit steps and drives the coin hopper one coin at a time.
- Uses 20-coins first and falls back to 10-coins when 20s run out.
- Tracks 10/20 coin stock, reports shortfall and hopper jams.
- Sits between the vend/change logic and the physical hopper; it is the paying-out end of the machine's coin path.

Parameters:
AMT_W, 3, width of amount/unpaid, in units of 10
CNT_W, 6, width of stock counters (saturate at 2^CNT_W-1)
INIT_10, 8, stock_10 value at reset
INIT_20, 8, stock_20 value at reset
ACK_TIMEOUT, 16, cycles to wait for hopper_ack before declaring a jam (>=2)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
req  in  1  start payout; sampled only in IDLE
amount  in  AMT_W  change owed in units of 10; latched with req
hopper_ack  in  1  hopper confirms the commanded coin was ejected
refill  in  1  load stock increments; honoured only in IDLE
refill_10  in  CNT_W  10-coins added on refill
refill_20  in  CNT_W  20-coins added on refill
busy  out  1  payout in progress (state != IDLE)
pay_10  out  1  eject-10 command, level, held until ack/timeout
pay_20  out  1  eject-20 command, level, held until ack/timeout
done  out  1  one-cycle pulse at end of payout
short  out  1  valid with done: full amount not paid
unpaid  out  AMT_W  valid with done: remaining units not paid
jam  out  1  sticky hopper-timeout flag
stock_10  out  CNT_W  current 10-coin stock
stock_20  out  CNT_W  current 20-coin stock

Behaviour:
- Reset (reset=0, async) values:
  - state IDLE
  - busy, pay_10, pay_20, done, short, jam = 0
  - unpaid = 0
  - stock_10 = INIT_10, stock_20 = INIT_20
  - remaining register = 0, timeout counter = 0
- Reset mid-payout aborts immediately. Stock keeps the reset values; coins already paid are not credited back.
- States: IDLE, SELECT, EJECT, DONE. All transitions occur on the rising clock edge.
- IDLE:
  - req=1 latches remaining=amount and goes to SELECT.
  - If jam=1, req instead goes straight to DONE with short=1 and unpaid=amount.
  - refill=1 (evaluated before req in the same cycle) adds refill_x to stock_x, saturating at max.
  - If refill and req occur in the same cycle, both are honoured; SELECT sees the updated stock.
- SELECT (one cycle, outputs pay_x=0):
  - remaining==0 -> DONE, short=0.
  - else remaining>=2 and stock_20>0 -> EJECT with coin=20.
  - else stock_10>0 -> EJECT with coin=10.
  - else -> DONE, short=1, unpaid=remaining.
- EJECT:
  - pay_20 or pay_10 = 1, never both; the timeout counter increments each cycle.
  - hopper_ack=1 -> drop pay_x next cycle, stock_x -= 1, remaining -= 2 (20) or 1 (10), clear counter, go to SELECT.
  - Counter reaches ACK_TIMEOUT with no ack -> jam=1, go to DONE with short=1, unpaid=remaining. Stock is not decremented.
- DONE: done=1 for exactly one cycle, short/unpaid valid in the same cycle, then IDLE.
- short and unpaid hold their values until the next DONE.
- Latency: req at edge N -> SELECT at N+1 -> pay_x asserted at N+2. amount=0 gives done at N+2.
- Ignored inputs:
  - hopper_ack outside EJECT.
  - req while busy.
  - refill while busy (no queuing).
- Arithmetic: remaining never underflows; 20 is chosen only when remaining>=2. Stock decrements never wrap, because a coin is selected only when its stock is >0.
- jam clears only by reset.

Test Plan:
- Reset, then req with amount=3, ack 2 cycles after each pay_x -> pay_20 then pay_10, done, short=0, unpaid=0, stock_20=7, stock_10=7.
- stock_20=0 via INIT_20=0, amount=4 -> four pay_10 pulses, done, short=0, stock_10=4.
- INIT_10=1, INIT_20=0, amount=3 -> one pay_10, then done with short=1, unpaid=2, stock_10=0.
- amount=2, hopper_ack held low -> pay_20 for exactly ACK_TIMEOUT cycles, then jam=1, done, short=1, unpaid=2, stock_20 unchanged. A later req with amount=1 -> immediate done, short=1, unpaid=1, no pay_x.
- amount=0 -> done 2 cycles after req, no pay_x. refill with refill_10=5 while busy -> stock unchanged. Same refill in IDLE at stock_10=60 -> stock_10=63 (saturated).
- reset driven low during EJECT -> pay_x, busy, and jam drop asynchronously, stock returns to INIT values, state is IDLE on release.
